rtc_bus_responder: RTL

Synthesizable responder for the multiplexed AD/CS/WR/RD address/data bus driven by the PicoBlaze top level. It decodes address and data phases, maintains a 16-entry register file and drives read data back onto the shared 8-bit `salient` bus. An optional BCD seconds/minutes/hours counter lets it stand in for the RTC chip in simulation and on the board.

---
 rtl/rtc_bus_responder.sv | 116 +++++++++++
 1 files changed

// File: rtl/rtc_bus_responder.sv
// Register-file responder for the multiplexed AD/CS/WR/RD bus with a shared 8-bit data bus.
// Define RTC_TICK_EN to turn 0x01-0x03 into a BCD seconds/minutes/hours counter.
module rtc_bus_responder #(
  parameter int unsigned CLK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       AD,
  input  logic       CS,
  input  logic       WR,
  input  logic       RD,
  inout  wire  [7:0] salient,
  output logic       drive_en,
  output logic [7:0] addr_q
);

  logic [1:0] ad_sync, cs_sync, wr_sync, rd_sync;
  logic [7:0] sal_meta, salient_s;
  logic       ad_s, cs_s, wr_s, rd_s, wr_prev;
  logic       wr_rise, rd_act, addr_hit;
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];
  logic [7:0] rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ad_sync   <= 2'b00;
      cs_sync   <= 2'b11;
      wr_sync   <= 2'b11;
      rd_sync   <= 2'b11;
      sal_meta  <= 8'h00;
      salient_s <= 8'h00;
      wr_prev   <= 1'b1;
    end else begin
      ad_sync   <= {ad_sync[0], AD};
      cs_sync   <= {cs_sync[0], CS};
      wr_sync   <= {wr_sync[0], WR};
      rd_sync   <= {rd_sync[0], RD};
      sal_meta  <= salient;
      salient_s <= sal_meta;
      wr_prev   <= wr_s;
    end
  end

  assign ad_s     = ad_sync[1];
  assign cs_s     = cs_sync[1];
  assign wr_s     = wr_sync[1];
  assign rd_s     = rd_sync[1];
  assign wr_rise  = wr_s & ~wr_prev & ~cs_s;
  // Requiring WR_s high keeps a simultaneous WR/RD strobe from ever driving the bus.
  assign rd_act   = ~cs_s & ~rd_s & ad_s & wr_s;
  assign addr_hit = (addr_q[7:4] == 4'h0);

`ifdef RTC_TICK_EN
  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LastCount = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic          tick;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h59) return 8'h00;
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return v + 8'h01;
  endfunction

  assign tick = ~regs_q[0][0] & (presc_q == LastCount);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else if (!regs_q[0][0]) begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end
`else
  logic unused_clk_div;
  assign unused_clk_div = ^CLK_DIV;
`endif

  always_comb begin
    regs_d = regs_q;
`ifdef RTC_TICK_EN
    if (tick) begin
      regs_d[1] = bcd_inc(regs_q[1]);
      if (regs_q[1] == 8'h59) begin
        regs_d[2] = bcd_inc(regs_q[2]);
        if (regs_q[2] == 8'h59) begin
          regs_d[3] = (regs_q[3] == 8'h23) ? 8'h00 : bcd_inc(regs_q[3]);
        end
      end
    end
`endif
    // Applied after the tick so a host write in the tick cycle wins for its register.
    if (wr_rise && ad_s && addr_hit) begin
      regs_d[addr_q[3:0]] = salient_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
      addr_q   <= 8'h00;
      drive_en <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      regs_q   <= regs_d;
      drive_en <= rd_act;
      if (wr_rise && !ad_s) addr_q <= salient_s;
      if (rd_act) rdata_q <= addr_hit ? regs_q[addr_q[3:0]] : 8'h00;
    end
  end

  assign salient = drive_en ? rdata_q : 8'hzz;

endmodule
